// File: rtl/smi_frame_arbiter_x2_if.sv
`default_nettype none
// ============================================================================
// Module      : smi_frame_arbiter_x2_if
// Description : One SMI flit stream. The source side drives ready/eofc/data
//               and the sink side drives stop.
//               A flit moves on any cycle where ready=1 and stop=0.
//   ready : flit valid (source -> sink)
//   eofc  : end-of-frame control, non-zero on the last flit of a frame
//   data  : flit payload, FlitWidth bytes
//   stop  : backpressure (sink -> source)
// Revision    : 1.0 - initial release
// ============================================================================
interface smi_frame_arbiter_x2_if #(
  parameter int FlitWidth = 16
) ();

  logic                   ready;
  logic [7:0]             eofc;
  logic [FlitWidth*8-1:0] data;
  logic                   stop;

  modport master (output ready, output eofc, output data, input stop);
  modport slave  (input ready, input eofc, input data, output stop);

endinterface
`default_nettype wire

// File: rtl/smi_frame_arbiter_x2.sv
`default_nettype none
// ============================================================================
// Module      : smi_frame_arbiter_x2
// Description : Merges two SMI input streams onto one registered SMI output.
//               Arbitration is round-robin and frame-atomic: once the first
//               flit of a frame is taken from one input, that input keeps
//               the grant until its last flit (eofc != 0) has been taken.
// Ports       : clk      - clock, rising edge
//               nrst     - asynchronous active-low reset
//               smi_in_a - input stream A (slave side)
//               smi_in_b - input stream B (slave side)
//               smi_out  - merged output stream (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module smi_frame_arbiter_x2 #(
  parameter int FlitWidth = 16,
  parameter int EofcMask  = 2*FlitWidth-1
) (
  input  logic                  clk,
  input  logic                  nrst,
  smi_frame_arbiter_x2_if.slave  smi_in_a,
  smi_frame_arbiter_x2_if.slave  smi_in_b,
  smi_frame_arbiter_x2_if.master smi_out
);

  localparam int         DataWidth = FlitWidth*8;
  localparam logic [7:0] EofcMaskC = 8'(EofcMask);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e                 state_q,     state_d;
  logic                   last_b_q,    last_b_d;    // 1: B held the most recent grant
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_eofc_q,  out_eofc_d;
  logic [DataWidth-1:0]   out_data_q,  out_data_d;

  logic out_free;
  logic sel_a;
  logic sel_b;
  logic xfer_a;
  logic xfer_b;

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    out_valid_d = out_valid_q;
    out_eofc_d  = out_eofc_q;
    out_data_d  = out_data_q;
    sel_a       = 1'b0;
    sel_b       = 1'b0;

    out_free = ~out_valid_q | ~smi_out.stop;

    case (state_q)
      GRANT_A: sel_a = 1'b1;
      GRANT_B: sel_b = 1'b1;
      default: begin
        // On a tie the input that did not hold the last grant wins.
        if (smi_in_a.ready && (!smi_in_b.ready || last_b_q)) begin
          sel_a = 1'b1;
        end else if (smi_in_b.ready) begin
          sel_b = 1'b1;
        end
      end
    endcase

    // nrst gating keeps both inputs stalled while reset is held.
    xfer_a = sel_a & smi_in_a.ready & out_free & nrst;
    xfer_b = sel_b & smi_in_b.ready & out_free & nrst;

    smi_in_a.stop = ~(sel_a & out_free & nrst);
    smi_in_b.stop = ~(sel_b & out_free & nrst);

    // The grant is only committed when a flit actually moves, so a stalled
    // tie in IDLE leaves lastGrant untouched and re-arbitrates next cycle.
    if (xfer_a) begin
      if (state_q == IDLE) begin
        last_b_d = 1'b0;
      end
      state_d = (smi_in_a.eofc != 8'h00) ? IDLE : GRANT_A;
    end else if (xfer_b) begin
      if (state_q == IDLE) begin
        last_b_d = 1'b1;
      end
      state_d = (smi_in_b.eofc != 8'h00) ? IDLE : GRANT_B;
    end

    if (xfer_a) begin
      out_valid_d = 1'b1;
      out_data_d  = smi_in_a.data;
      out_eofc_d  = smi_in_a.eofc & EofcMaskC;
    end else if (xfer_b) begin
      out_valid_d = 1'b1;
      out_data_d  = smi_in_b.data;
      out_eofc_d  = smi_in_b.eofc & EofcMaskC;
    end else if (!smi_out.stop) begin
      out_valid_d = 1'b0;
    end
  end

  assign smi_out.ready = out_valid_q;
  assign smi_out.data  = out_data_q;
  assign smi_out.eofc  = out_eofc_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload registers carry no reset; out_valid_q qualifies them.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    out_eofc_q <= out_eofc_d;
  end

endmodule
`default_nettype wire
